// File: rtl/mem_access_sequencer_if.sv
// Handshake bundle between the control unit, the sequencer and the data RAM.
// The slave modport is the sequencer's view; the master modport is the environment's.
interface mem_access_sequencer_if;
  logic        req;
  logic        rw;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic        mfa;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        moc;

  modport slave (
    input  req, rw, size, sign_ext, addr,
    input  wdata0, wdata1, mem_rdata, moc,
    output busy, done, err_code, rdata0, rdata1,
    output mfa, mem_rw, mem_size, mem_addr, mem_wdata
  );

  modport master (
    output req, rw, size, sign_ext, addr,
    output wdata0, wdata1, mem_rdata, moc,
    input  busy, done, err_code, rdata0, rdata1,
    input  mfa, mem_rw, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Sequences one load/store request into one or two MFA/MOC RAM accesses,
// with doubleword split, load extension, misalignment and timeout reporting.
module mem_access_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   reset_n,
  mem_access_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_ACC1, S_GAP, S_ACC2, S_DONE
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_rw;
  logic [1:0]  r_size;
  logic        r_sext;
  logic [31:0] r_addr;
  logic [31:0] r_wdata1;
  logic [7:0]  r_cnt;
  logic [1:0]  r_err;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;
  logic        r_mem_rw;
  logic [1:0]  r_mem_size;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        w_misal;
  logic        w_acc;
  logic        w_last;
  logic        w_accept;
  logic [31:0] w_ext;

  always_comb begin
    w_misal = 1'b0;
    unique case (bus.size)
      2'b00: w_misal = 1'b0;
      2'b01: w_misal = bus.addr[0];
      2'b10: w_misal = |bus.addr[1:0];
      2'b11: w_misal = |bus.addr[2:0];
    endcase
  end

  always_comb begin
    w_ext = bus.mem_rdata;
    unique case (r_size)
      2'b00: w_ext = {{24{r_sext & bus.mem_rdata[7]}},
                      bus.mem_rdata[7:0]};
      2'b01: w_ext = {{16{r_sext & bus.mem_rdata[15]}},
                      bus.mem_rdata[15:0]};
      default: w_ext = bus.mem_rdata;
    endcase
  end

  assign w_acc    = (r_state == S_ACC1) || (r_state == S_ACC2);
  assign w_last   = (r_cnt == LP_LAST);
  assign w_accept = (r_state == S_IDLE) && bus.req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.req) w_next = w_misal ? S_DONE : S_ACC1;
      S_ACC1: begin
        if (bus.moc)
          w_next = (r_size == 2'b11) ? S_GAP : S_DONE;
        else if (w_last)
          w_next = S_DONE;
      end
      S_GAP:  w_next = S_ACC2;
      S_ACC2: if (bus.moc || w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rw        <= 1'b0;
      r_size      <= 2'b00;
      r_sext      <= 1'b0;
      r_addr      <= '0;
      r_wdata1    <= '0;
      r_cnt       <= '0;
      r_err       <= 2'b00;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_mem_rw    <= 1'b0;
      r_mem_size  <= 2'b00;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_acc && !bus.moc) r_cnt <= r_cnt + 8'd1;
      else                   r_cnt <= '0;
      if (w_accept) begin
        r_rw     <= bus.rw;
        r_size   <= bus.size;
        r_sext   <= bus.sign_ext;
        r_addr   <= bus.addr;
        r_wdata1 <= bus.wdata1;
        r_err    <= w_misal ? 2'b01 : 2'b00;
        // RAM-side outputs keep their old values on a rejected request
        if (!w_misal) begin
          r_mem_addr  <= bus.addr;
          r_mem_rw    <= bus.rw;
          r_mem_size  <= (bus.size == 2'b11) ? 2'b10 : bus.size;
          r_mem_wdata <= bus.wdata0;
        end
      end
      if (r_state == S_GAP) begin
        r_mem_addr  <= r_addr + 32'd4;
        r_mem_wdata <= r_wdata1;
      end
      if (w_acc && bus.moc && r_rw) begin
        if (r_state == S_ACC1) r_rdata0 <= w_ext;
        else                   r_rdata1 <= w_ext;
      end
      if (w_acc && !bus.moc && w_last) r_err <= 2'b10;
    end
  end

  assign bus.mfa       = w_acc;
  assign bus.busy      = w_acc || (r_state == S_GAP);
  assign bus.done      = (r_state == S_DONE);
  assign bus.err_code  = bus.done ? r_err : 2'b00;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.mem_rw    = r_mem_rw;
  assign bus.mem_size  = r_mem_size;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Sequences every data-memory transaction the ARM control unit issues. It accepts one load/store request of byte, halfword, word or doubleword size and drives the RAM's MFA/MOC handshake. It splits doublewords into two word accesses, applies sign/zero extension to loaded data and reports misalignment or MOC timeout. It sits between the control-unit state machine and the RAM, so the control unit waits on a single `done` instead of spinning on MOC.

## Interface
- `TIMEOUT`, default 15: maximum number of cycles MFA stays asserted per access without MOC before an access is aborted; legal range 1..255.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in 1: start request; sampled only in IDLE.
- `rw` in 1: 1 = load (read), 0 = store (write).
- `size` in 2: 00 byte, 01 halfword, 10 word, 11 doubleword.
- `sign_ext` in 1: sign-extend byte/halfword loads (0 = zero-extend).
- `addr` in 32: byte address.
- `wdata0` in 32: store data, first or only word.
- `wdata1` in 32: store data, second word of a doubleword.
- `busy` out 1: high from the cycle after an accepted `req` through the last access.
- `done` out 1: one-cycle completion pulse.
- `err_code` out 2: 00 ok, 01 misaligned, 10 timeout; valid only while `done`=1, otherwise 00.
- `rdata0` out 32: load result, first or only word.
- `rdata1` out 32: load result, second word of a doubleword.
- `mfa`, `mem_rw` out 1: RAM handshake and direction.
- `mem_size` out 2: 00 byte, 01 half, 10 word.
- `mem_addr`, `mem_wdata` out 32: RAM address and store data.
- `mem_rdata` in 32: RAM read data, right-aligned for byte/half.
- `moc` in 1: RAM operation complete.

## Operation
- States: IDLE, ACC1, GAP, ACC2, DONE.
- **IDLE**
  - `req`=1 latches `rw`, `size`, `sign_ext`, `addr`, `wdata0` and `wdata1`.
  - Alignment rules: half needs `addr[0]`=0, word needs `addr[1:0]`=0, dword needs `addr[2:0]`=0.
  - Misaligned goes to DONE with `err_code`=01 and never asserts MFA.
  - Aligned goes to ACC1.
- **ACC1**
  - Drives `mfa`=1, `mem_addr`=latched addr and `mem_rw`=latched rw.
  - `mem_size` = latched size, with dword mapped to 10.
  - `mem_wdata`=wdata0.
  - Wait counter clears on entry and increments each cycle `moc`=0.
- **On `moc`=1 in ACC1/ACC2**
  - For loads, captures `mem_rdata` into `rdata0` (ACC1) or `rdata1` (ACC2).
  - Byte: bits 31:8 = sign_ext ? bit 7 : 0.
  - Half: bits 31:16 = sign_ext ? bit 15 : 0.
  - Word: unmodified.
  - Stores leave `rdata*` unchanged.
  - ACC1 of a dword then goes to GAP; otherwise goes to DONE.
- **Timeout**: if `moc`=0 in the cycle where counter = TIMEOUT−1, go to DONE with `err_code`=10. `moc`=1 in that same cycle wins and completes normally.
- **GAP**: `mfa`=0 for exactly one cycle, then ACC2.
- **ACC2**
  - Same as ACC1 but with `mem_addr`=addr+4 (32-bit wrap at 0xFFFFFFFC→0x00000000) and `mem_wdata`=wdata1.
  - A timeout in ACC2 reports 10; `rdata0` keeps the first word.
- **DONE**: `done`=1 and `busy`=0, then IDLE. `req` is ignored in DONE.
- **Outputs outside ACC1/ACC2**: `mfa`=0. `mem_addr`, `mem_rw`, `mem_size` and `mem_wdata` hold their last values.
- **Reset**
  - Takes effect asynchronously; state returns to IDLE.
  - Every output goes to 0, including `mfa` mid-access.
  - Latches and counter clear.
  - No `done` is produced for an aborted request.

## Timing
- **Request acceptance**: `req` is sampled at edge E0 in IDLE; ACC1 (`mfa`=1, `busy`=1) is active from E0.
- **Single access**
  - With `moc` high k cycles after MFA rises (k≥0), data is captured at edge E0+1+k.
  - `done` is high during cycle E0+1+k, and IDLE follows next.
  - Minimum `req`-to-`done` is 1 cycle; MFA stays high for k+1 cycles.
- **Doubleword**: ACC1 (k1+1 cycles), GAP (1), ACC2 (k2+1), DONE. Minimum is 4 cycles from acceptance to the `done` cycle inclusive.
- **Misaligned request**: `done` (err 01) follows in the cycle after acceptance.
- **Timed-out access**: `mfa` is high for exactly TIMEOUT cycles, then `done` (err 10).
- **Back-to-back requests**: the earliest next `req` sample is the IDLE cycle after DONE.
- **Output stability**: `rdata0`/`rdata1` are stable from the `done` cycle until the next load capture.

## Test plan
- Word load at 0x100, moc after 2 cycles, mem_rdata=0x89ABCDEF → mfa high 3 cycles, done with err 00, rdata0=0x89ABCDEF.
- Byte load, sign_ext=1, mem_rdata=0x00000080 → rdata0=0xFFFFFF80; repeat with sign_ext=0 → 0x00000080. Half, sign_ext=1, 0x0000F00D → 0xFFFFF00D.
- Dword store at 0x208, wdata0=0x11111111, wdata1=0x22222222, immediate moc → access 1 at 0x208/0x11111111, one mfa-low gap, access 2 at 0x20C/0x22222222, then done.
- Word load at 0x102 → done with err 01 one cycle after acceptance; mfa never asserted. TIMEOUT=4 with moc never high → mfa high exactly 4 cycles, then err 10. moc arriving in the 4th cycle → err 00.
- reset_n low during ACC2 of a dword load → mfa drops immediately, no done pulse, all outputs 0; after release, a new word load completes normally.
- req held high across DONE → second request is accepted only in the following IDLE cycle; exactly two done pulses.
